// File: rtl/hring_eject_if.sv
// Ejection link between the hierarchical-ring router, the eject buffer and the local node.
// The master side is the router/node pair. The slave side is the buffer.
interface hring_eject_if #(
  parameter int FLIT_W = 144,
  parameter int CNT_W  = 3
);
  logic [FLIT_W-1:0] eject;
  logic              push;
  logic              bfull;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output eject, push, out_ready,
    input  bfull, out_flit, out_valid, count, overflow
  );

  modport slave (
    input  eject, push, out_ready,
    output bfull, out_flit, out_valid, count, overflow
  );
endinterface

// File: rtl/hring_eject_buffer.sv
// In-order FIFO for flits ejected by the ring router toward the local node.
// bfull is raised early enough to cover the one flit still in flight behind it.
module hring_eject_buffer #(
  parameter int FLIT_W = 144,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int SLACK  = 1
) (
  input logic          clk,
  input logic          rst,
  hring_eject_if.slave eif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              bfull_q, ovf_q;
  logic              pop, accept;

  always_comb begin
    pop      = (cnt != '0) & eif.out_ready;
    accept   = eif.push & ((cnt < CNT_W'(DEPTH)) | pop);
    cnt_next = cnt + CNT_W'(accept) - CNT_W'(pop);
  end

  // Storage is left uncleared; only the pointers and count define the contents.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= eif.eject;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      bfull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      cnt     <= cnt_next;
      bfull_q <= (cnt_next >= CNT_W'(DEPTH - SLACK));
      if (eif.push & ~accept) ovf_q <= 1'b1;
    end
  end

  assign eif.out_flit  = mem[rd_ptr];
  assign eif.out_valid = (cnt != '0);
  assign eif.count     = cnt;
  assign eif.bfull     = bfull_q;
  assign eif.overflow  = ovf_q;
endmodule

// File: tb/tb_hring_eject_buffer.sv
// Directed bench for hring_eject_buffer: single flit, fill, overflow, full push+pop with wrap,
// bfull release and mid-cycle asynchronous reset.
module tb_hring_eject_buffer;
  localparam int FLIT_W = 144;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hring_eject_if #(.FLIT_W(FLIT_W), .CNT_W(CNT_W)) eif ();

  hring_eject_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .SLACK(1)) dut (
    .clk (clk),
    .rst (rst),
    .eif (eif)
  );

  task automatic chk(input string tag, input logic [FLIT_W-1:0] got, input logic [FLIT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int n);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1 -: 16] = 16'hA5C3;
    f[31:0] = 32'(n) * 32'h0101_0101;
    return f;
  endfunction

  logic [FLIT_W-1:0] f1;
  logic [FLIT_W-1:0] exp_head;

  initial begin
    f1 = 144'h0111_1111_1111_1111_1111_1111_1111_1111_1854;
    eif.push      = 1'b0;
    eif.eject     = 'x;
    eif.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_count", FLIT_W'(eif.count), 0);
    chk("rst_valid", FLIT_W'(eif.out_valid), 0);
    chk("rst_bfull", FLIT_W'(eif.bfull), 0);
    chk("rst_ovf",   FLIT_W'(eif.overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1. Single flit
    eif.push = 1'b1; eif.eject = f1;
    tick();
    eif.push = 1'b0; eif.eject = 'x;
    chk("t1_valid", FLIT_W'(eif.out_valid), 1);
    chk("t1_flit",  eif.out_flit, f1);
    chk("t1_count", FLIT_W'(eif.count), 1);
    chk("t1_bfull", FLIT_W'(eif.bfull), 0);
    eif.out_ready = 1'b1;
    tick();
    eif.out_ready = 1'b0;
    chk("t1_pop_count", FLIT_W'(eif.count), 0);
    chk("t1_pop_valid", FLIT_W'(eif.out_valid), 0);

    // Idle cycle with push=0 must not disturb anything
    tick();
    chk("idle_count", FLIT_W'(eif.count), 0);

    // 2. Fill with A..D (flits 1..4)
    for (int i = 1; i <= 3; i++) begin
      eif.push = 1'b1; eif.eject = mk(i);
      tick();
      chk($sformatf("t2_count%0d", i), FLIT_W'(eif.count), FLIT_W'(i));
      chk($sformatf("t2_bfull%0d", i), FLIT_W'(eif.bfull), (i == 3) ? 1 : 0);
    end
    eif.eject = mk(4);
    tick();
    chk("t2_d_count", FLIT_W'(eif.count), 4);
    chk("t2_d_ovf",   FLIT_W'(eif.overflow), 0);
    chk("t2_d_bfull", FLIT_W'(eif.bfull), 1);

    // 3. Overflow: E (flit 5) dropped
    eif.eject = mk(5);
    tick();
    eif.push = 1'b0; eif.eject = 'x;
    chk("t3_ovf",   FLIT_W'(eif.overflow), 1);
    chk("t3_count", FLIT_W'(eif.count), 4);
    chk("t3_head",  eif.out_flit, mk(1));
    tick();
    chk("t3_ovf_sticky", FLIT_W'(eif.overflow), 1);
    eif.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t3_drain%0d", i), eif.out_flit, mk(i));
      tick();
    end
    eif.out_ready = 1'b0;
    chk("t3_empty_count", FLIT_W'(eif.count), 0);
    chk("t3_empty_valid", FLIT_W'(eif.out_valid), 0);

    // 4. Refill with flits 10..13, then 8 back-to-back push+pop (flits 20..27) across wrap
    eif.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eif.eject = mk(10 + i);
      tick();
    end
    chk("t4_full", FLIT_W'(eif.count), 4);
    eif.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_head = (i < 4) ? mk(10 + i) : mk(20 + i - 4);
      chk($sformatf("t4_head%0d", i), eif.out_flit, exp_head);
      eif.eject = mk(20 + i);
      tick();
      chk($sformatf("t4_count%0d", i), FLIT_W'(eif.count), 4);
    end
    chk("t4_ovf_unchanged", FLIT_W'(eif.overflow), 1);
    chk("t4_head_after", eif.out_flit, mk(24));

    // 5. bfull release: 4 -> 3 keeps bfull, 3 -> 2 drops it on the same edge
    eif.push = 1'b0; eif.eject = 'x;
    tick();
    chk("t5_count3", FLIT_W'(eif.count), 3);
    chk("t5_bfull3", FLIT_W'(eif.bfull), 1);
    chk("t5_head",   eif.out_flit, mk(25));
    tick();
    eif.out_ready = 1'b0;
    chk("t5_count2", FLIT_W'(eif.count), 2);
    chk("t5_bfull2", FLIT_W'(eif.bfull), 0);

    // 6. Async reset pulsed mid-cycle with count=2, overflow=1
    #2;
    rst = 1'b1;
    #1;
    chk("t6_count", FLIT_W'(eif.count), 0);
    chk("t6_valid", FLIT_W'(eif.out_valid), 0);
    chk("t6_bfull", FLIT_W'(eif.bfull), 0);
    chk("t6_ovf",   FLIT_W'(eif.overflow), 0);
    #1;
    rst = 1'b0;
    eif.push = 1'b1; eif.eject = mk(40);
    tick();
    eif.push = 1'b0; eif.eject = 'x;
    chk("t6_post_count", FLIT_W'(eif.count), 1);
    chk("t6_post_flit",  eif.out_flit, mk(40));
    eif.out_ready = 1'b1;
    tick();
    eif.out_ready = 1'b0;
    chk("t6_post_empty", FLIT_W'(eif.count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
